// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the miniRV core with retire counter, halt and memory-timeout fault.
// Latency: strobes are combinational from the state register and rdy inputs; 3-5 cycles per instruction plus one per rdy-low wait cycle.
// Backpressure: FETCH waits on imem_rdy and MEM waits on dmem_rdy; TIMEOUT consecutive not-ready cycles latch err and park in HALT.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ins,
    input  logic        imem_rdy,
    input  logic        dmem_rdy,
    output logic        imem_req,
    output logic        ir_wen,
    output logic        pc_wen,
    output logic        rf_wen,
    output logic        dmem_req,
    output logic        dram_wen,
    output logic [2:0]  state,
    output logic [31:0] instret,
    output logic        halted,
    output logic        err
);

    // The wait counter only ever holds 0..TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(TIMEOUT - 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_HALT   = 7'b1111111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t         cur_st;
    state_t         nxt_st;
    logic [WCW-1:0] wait_cnt;
    logic           wait_inc;
    logic           wait_clr;
    logic           fault;

    logic [6:0]     opcode;
    logic           is_load;
    logic           is_store;
    logic           is_halt;
    logic           is_wb;

    // Upper instruction bits belong to the datapath decoder, not to sequencing.
    logic           unused_ins;
    assign unused_ins = ^ins[31:7];

    assign opcode = ins[6:0];

    // Opcode classes; branch and unrecognised opcodes both fall out as "neither of these".
    always_comb begin
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        is_halt  = (opcode == OP_HALT);
        is_wb    = 1'b0;
        case (opcode)
            OP_RTYPE, OP_ITYPE, OP_JALR,
            OP_LUI, OP_AUIPC, OP_JAL: is_wb = 1'b1;
            OP_BRANCH:                is_wb = 1'b0;
            default:                  is_wb = 1'b0;
        endcase
    end

    // Next-state and strobe decode; every strobe is a one-cycle pulse consumed on the next edge.
    always_comb begin
        nxt_st   = cur_st;
        imem_req = 1'b0;
        ir_wen   = 1'b0;
        pc_wen   = 1'b0;
        rf_wen   = 1'b0;
        dmem_req = 1'b0;
        dram_wen = 1'b0;
        wait_inc = 1'b0;
        fault    = 1'b0;
        case (cur_st)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_rdy) begin
                    // The IR must not load while reset is holding the block in FETCH.
                    ir_wen = ~rst;
                    nxt_st = S_DECODE;
                end else if (wait_cnt == WAIT_MAX) begin
                    fault  = 1'b1;
                    nxt_st = S_HALT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_DECODE: begin
                nxt_st = is_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (is_load || is_store) begin
                    nxt_st = S_MEM;
                end else if (is_wb) begin
                    nxt_st = S_WB;
                end else begin
                    // Branch or unknown opcode: nothing left to do but advance the PC.
                    pc_wen = 1'b1;
                    nxt_st = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (dmem_rdy) begin
                    if (is_store) begin
                        dram_wen = 1'b1;
                        pc_wen   = 1'b1;
                        nxt_st   = S_FETCH;
                    end else begin
                        nxt_st = S_WB;
                    end
                end else if (wait_cnt == WAIT_MAX) begin
                    fault  = 1'b1;
                    nxt_st = S_HALT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_WB: begin
                rf_wen = 1'b1;
                pc_wen = 1'b1;
                nxt_st = S_FETCH;
            end
            S_HALT: begin
                nxt_st = S_HALT;
            end
            default: begin
                nxt_st = S_FETCH;
            end
        endcase
    end

    // Waiting restarts from zero whenever a wait state is freshly entered.
    assign wait_clr = (nxt_st != cur_st) && ((nxt_st == S_FETCH) || (nxt_st == S_MEM));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_st <= S_FETCH;
        end else begin
            cur_st <= nxt_st;
        end
    end

    // Consecutive not-ready cycle counter for the current wait state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (wait_clr) begin
            wait_cnt <= '0;
        end else if (wait_inc) begin
            wait_cnt <= wait_cnt + WCW'(1);
        end
    end

    // Retired-instruction counter; an instruction retires exactly when the PC advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (pc_wen) begin
            instret <= instret + 32'd1;
        end
    end

    // Sticky timeout fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (fault) begin
            err <= 1'b1;
        end
    end

    assign state  = cur_st;
    assign halted = (cur_st == S_HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
    localparam int TIMEOUT = 16;

    localparam logic [31:0] I_ADD    = 32'h00208033;
    localparam logic [31:0] I_LOAD   = 32'h0000A083;
    localparam logic [31:0] I_STORE  = 32'h0020A023;
    localparam logic [31:0] I_BRANCH = 32'h00208463;
    localparam logic [31:0] I_HALT   = 32'h0000007F;
    localparam logic [31:0] I_UNK    = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ins;
    logic        imem_rdy;
    logic        dmem_rdy;
    logic        imem_req;
    logic        ir_wen;
    logic        pc_wen;
    logic        rf_wen;
    logic        dmem_req;
    logic        dram_wen;
    logic [2:0]  state;
    logic [31:0] instret;
    logic        halted;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .ins      (ins),
        .imem_rdy (imem_rdy),
        .dmem_rdy (dmem_rdy),
        .imem_req (imem_req),
        .ir_wen   (ir_wen),
        .pc_wen   (pc_wen),
        .rf_wen   (rf_wen),
        .dmem_req (dmem_req),
        .dram_wen (dram_wen),
        .state    (state),
        .instret  (instret),
        .halted   (halted),
        .err      (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Class: 0 writeback, 1 load, 2 store, 3 branch/unknown, 4 halt.
    function automatic int op_class(input logic [31:0] i);
        logic [6:0] op;
        op = i[6:0];
        case (op)
            7'b0000011: return 1;
            7'b0100011: return 2;
            7'b1111111: return 4;
            7'b0110011, 7'b0010011, 7'b1100111,
            7'b0110111, 7'b0010111, 7'b1101111: return 0;
            default: return 3;
        endcase
    endfunction

    // Step-by-step state visited by each class; the halt class parks after its second step.
    int seq_tbl [5][5] = '{'{0, 1, 2, 4, 0},
                           '{0, 1, 2, 3, 4},
                           '{0, 1, 2, 3, 0},
                           '{0, 1, 2, 0, 0},
                           '{0, 1, 0, 0, 0}};
    int seq_len [5]    = '{4, 5, 4, 3, 2};

    int          m_idx     = 0;
    int          m_wait    = 0;
    logic [31:0] m_instret = 32'd0;
    bit          m_err     = 1'b0;
    bit          m_halt    = 1'b0;

    int u_cls;
    int u_st;
    bit u_rdy;

    // Model advance on each clock edge, reset asynchronously like the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idx     <= 0;
            m_wait    <= 0;
            m_instret <= 32'd0;
            m_err     <= 1'b0;
            m_halt    <= 1'b0;
        end else if (!m_halt) begin
            u_cls = op_class(ins);
            u_st  = seq_tbl[u_cls][m_idx];
            u_rdy = (u_st == 0) ? imem_rdy : ((u_st == 3) ? dmem_rdy : 1'b1);
            if (!u_rdy) begin
                if (m_wait == TIMEOUT - 1) begin
                    m_err  <= 1'b1;
                    m_halt <= 1'b1;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end else if (u_cls == 4 && m_idx == 1) begin
                m_halt <= 1'b1;
            end else if (m_idx == seq_len[u_cls] - 1) begin
                m_idx     <= 0;
                m_wait    <= 0;
                m_instret <= m_instret + 32'd1;
            end else begin
                m_idx <= m_idx + 1;
                if (seq_tbl[u_cls][m_idx + 1] == 3) m_wait <= 0;
            end
        end
    end

    int c_cls;
    int c_st;
    bit c_rdy;
    bit c_last;

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            c_cls  = op_class(ins);
            c_st   = m_halt ? 5 : seq_tbl[c_cls][m_idx];
            c_rdy  = (c_st == 0) ? imem_rdy : ((c_st == 3) ? dmem_rdy : 1'b1);
            c_last = !m_halt && c_cls != 4 && m_idx == seq_len[c_cls] - 1;
            check("m_state",    32'(state),    32'(c_st));
            check("m_imem_req", 32'(imem_req), 32'(c_st == 0));
            check("m_ir_wen",   32'(ir_wen),   32'(c_st == 0 && imem_rdy && !rst));
            check("m_pc_wen",   32'(pc_wen),   32'(c_last && c_rdy));
            check("m_rf_wen",   32'(rf_wen),   32'(c_st == 4));
            check("m_dmem_req", 32'(dmem_req), 32'(c_st == 3));
            check("m_dram_wen", 32'(dram_wen), 32'(c_st == 3 && c_cls == 2 && dmem_rdy));
            check("m_instret",  instret,       m_instret);
            check("m_halted",   32'(halted),   32'(m_halt));
            check("m_err",      32'(err),      32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        imem_rdy = 1'b0;
        dmem_rdy = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    // Runs one instruction from FETCH: fw fetch waits, mw memory waits, lat zero-wait latency.
    task automatic run_instr(input logic [31:0] iv, input int fw, input int mw, input int lat,
                             output int c_ir, output int c_pc, output int c_rf,
                             output int c_dreq, output int c_dwen);
        c_ir = 0; c_pc = 0; c_rf = 0; c_dreq = 0; c_dwen = 0;
        ins = iv;
        for (int k = 0; k < lat + fw + mw; k++) begin
            imem_rdy = (k == fw);
            dmem_rdy = !(k >= fw + 3 && k < fw + 3 + mw);
            #3;
            c_ir   += int'(ir_wen);
            c_pc   += int'(pc_wen);
            c_rf   += int'(rf_wen);
            c_dreq += int'(dmem_req);
            c_dwen += int'(dram_wen);
            next_cycle();
        end
        imem_rdy = 1'b0;
    endtask

    int n_ir, n_pc, n_rf, n_dreq, n_dwen;

    initial begin
        rst      = 1'b1;
        ins      = 32'd0;
        imem_rdy = 1'b0;
        dmem_rdy = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_state",    32'(state),    32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd1);
        check("rst_instret",  instret,       32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_halted",   32'(halted),   32'd0);
        check("rst_pc_wen",   32'(pc_wen),   32'd0);
        next_cycle();
        rst = 1'b0;

        // Zero-wait add: F D E W.
        ins = I_ADD;
        imem_rdy = 1'b1;
        #1;
        check("add_c0_ir_wen", 32'(ir_wen), 32'd1);
        run_instr(I_ADD, 0, 0, 4, n_ir, n_pc, n_rf, n_dreq, n_dwen);
        check("add_instret", instret, 32'd1);
        check("add_rf_cnt",  32'(n_rf), 32'd1);
        check("add_pc_cnt",  32'(n_pc), 32'd1);
        check("add_back_fetch", 32'(state), 32'd0);

        // Load with three not-ready MEM cycles: 5 + 3 = 8 cycles.
        run_instr(I_LOAD, 0, 3, 5, n_ir, n_pc, n_rf, n_dreq, n_dwen);
        check("load_dreq_cnt", 32'(n_dreq), 32'd4);
        check("load_dwen_cnt", 32'(n_dwen), 32'd0);
        check("load_rf_cnt",   32'(n_rf),   32'd1);
        check("load_instret",  instret,     32'd2);

        // Store then branch, then an unknown opcode.
        do_reset();
        run_instr(I_STORE, 0, 0, 4, n_ir, n_pc, n_rf, n_dreq, n_dwen);
        check("store_dwen_cnt", 32'(n_dwen), 32'd1);
        check("store_rf_cnt",   32'(n_rf),   32'd0);
        run_instr(I_BRANCH, 0, 0, 3, n_ir, n_pc, n_rf, n_dreq, n_dwen);
        check("branch_rf_cnt", 32'(n_rf), 32'd0);
        check("branch_pc_cnt", 32'(n_pc), 32'd1);
        check("sb_instret",    instret,   32'd2);
        run_instr(I_UNK, 1, 0, 3, n_ir, n_pc, n_rf, n_dreq, n_dwen);
        check("unk_instret", instret, 32'd3);

        // Halt opcode parks the block.
        do_reset();
        ins = I_HALT;
        imem_rdy = 1'b1;
        next_cycle();
        check("halt_decode", 32'(state), 32'd1);
        next_cycle();
        check("halt_state",  32'(state),  32'd5);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_err",    32'(err),    32'd0);
        dmem_rdy = 1'b1;
        n_ir = 0; n_pc = 0; n_rf = 0; n_dwen = 0;
        for (int k = 0; k < 10; k++) begin
            n_ir += int'(ir_wen || imem_req);
            n_pc += int'(pc_wen || rf_wen);
            n_dwen += int'(dram_wen || dmem_req);
            next_cycle();
        end
        check("halt_no_fetch",  32'(n_ir),   32'd0);
        check("halt_no_wr",     32'(n_pc),   32'd0);
        check("halt_no_mem",    32'(n_dwen), 32'd0);
        check("halt_instret",   instret,     32'd0);

        // Fetch timeout: 16 not-ready cycles fault.
        do_reset();
        ins = I_ADD;
        for (int k = 0; k < 15; k++) next_cycle();
        check("to_still_fetch", 32'(state), 32'd0);
        check("to_no_err_yet",  32'(err),   32'd0);
        next_cycle();
        check("to_state", 32'(state), 32'd5);
        check("to_err",   32'(err),   32'd1);

        // Ready in the 16th cycle wins over the fault.
        do_reset();
        ins = I_ADD;
        for (int k = 0; k < 15; k++) next_cycle();
        imem_rdy = 1'b1;
        #1;
        check("to_rdy_ir_wen", 32'(ir_wen), 32'd1);
        next_cycle();
        imem_rdy = 1'b0;
        check("to_rdy_decode", 32'(state), 32'd1);
        check("to_rdy_err",    32'(err),   32'd0);
        for (int k = 0; k < 3; k++) next_cycle();
        check("to_rdy_instret", instret, 32'd1);

        // MEM timeout on a load.
        do_reset();
        ins = I_LOAD;
        imem_rdy = 1'b1;
        next_cycle();
        imem_rdy = 1'b0;
        for (int k = 0; k < 2 + 15; k++) next_cycle();
        check("memto_in_mem", 32'(state), 32'd3);
        next_cycle();
        check("memto_state", 32'(state), 32'd5);
        check("memto_err",   32'(err),   32'd1);

        // Reset pulse in the middle of a store's MEM cycle.
        do_reset();
        ins = I_STORE;
        imem_rdy = 1'b1;
        next_cycle();
        imem_rdy = 1'b0;
        next_cycle();
        next_cycle();
        check("mr_in_mem", 32'(state), 32'd3);
        dmem_rdy = 1'b1;
        #1;
        check("mr_pre_dwen", 32'(dram_wen), 32'd1);
        rst = 1'b1;
        #1;
        check("mr_state",    32'(state),    32'd0);
        check("mr_instret",  instret,       32'd0);
        check("mr_dram_wen", 32'(dram_wen), 32'd0);
        check("mr_pc_wen",   32'(pc_wen),   32'd0);
        next_cycle();
        rst = 1'b0;
        imem_rdy = 1'b1;
        #1;
        check("mr_refetch_ir", 32'(ir_wen), 32'd1);
        next_cycle();
        imem_rdy = 1'b0;
        check("mr_decode", 32'(state), 32'd1);
        for (int k = 0; k < 3; k++) next_cycle();
        check("mr_instret_after", instret, 32'd1);

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
